tdc_hit_pipeline: RTL and testbench

//  Parametrised successor to the fixed single-stage start-sampling register bank of the TDC.

---
 rtl/tdc_hit_pipeline.sv | 116 +++++++++++
 tb/tb_tdc_hit_pipeline.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tdc_hit_pipeline.sv
// TDC start-hit pipeline: multi-stage tap sampling, tap-0 hit detection, dead time, hit counting.
// Optional majority-3 bubble filter on the captured word: define TDC_PIPE_BUBBLE_FILTER_EN.
module tdc_hit_pipeline #(
  parameter int NFF         = 208,
  parameter int NSTAGES     = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NFF-1:0]   pipe_in,
  output logic [NFF-1:0]   pipe_out,
  output logic [NFF-1:0]   hit_word,
  output logic             hit_valid,
  output logic             busy,
  output logic [CNT_W-1:0] hit_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DEAD    = 2'd2;
  localparam logic [1:0] REARM   = 2'd3;

  localparam int DW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [NFF-1:0]   stages [NSTAGES];
  logic [1:0]       state;
  logic [DW-1:0]    dead_cnt;
  logic             prev_b0;
  logic             rise;
  logic [NFF-1:0]   capture_word;

`ifdef TDC_PIPE_BUBBLE_FILTER_EN
  // Neighbours outside the chain are pinned: below tap 0 reads as 1, above the top tap as 0.
  function automatic logic [NFF-1:0] maj_filter(input logic [NFF-1:0] p);
    logic [NFF+1:0] x;
    logic [NFF-1:0] f;
    x = {1'b0, p, 1'b1};
    for (int k = 0; k < NFF; k++) begin
      f[k] = (x[k] & x[k+1]) | (x[k+1] & x[k+2]) | (x[k] & x[k+2]);
    end
    return f;
  endfunction

  assign capture_word = maj_filter(pipe_out);
`else
  assign capture_word = pipe_out;
`endif

  // Metastability/sampling stages, all held when en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSTAGES; i++) begin
        stages[i] <= '0;
      end
    end else if (en) begin
      stages[0] <= pipe_in;
      for (int i = 1; i < NSTAGES; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign pipe_out = stages[NSTAGES-1];
  assign rise     = pipe_out[0] & ~prev_b0;

  // Hit FSM, dead-time counter, snapshot and saturating hit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dead_cnt  <= '0;
      prev_b0   <= 1'b0;
      hit_word  <= '0;
      hit_count <= '0;
    end else if (en) begin
      prev_b0 <= pipe_out[0];
      case (state)
        IDLE: begin
          if (rise) begin
            hit_word <= capture_word;
            if (hit_count != {CNT_W{1'b1}}) begin
              hit_count <= hit_count + CNT_W'(1);
            end
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          dead_cnt <= DW'(HOLD_CYCLES - 1);
          state    <= DEAD;
        end
        DEAD: begin
          // Edges arriving during dead time are dropped, not queued.
          if (dead_cnt == '0) begin
            state <= REARM;
          end else begin
            dead_cnt <= dead_cnt - DW'(1);
          end
        end
        REARM: begin
          if (!pipe_out[0]) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobe is a decode of the registered state; a stalled CAPTURE is reported once en returns.
  assign hit_valid = (state == CAPTURE) & en & ~rst;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_tdc_hit_pipeline.sv
// Directed, table-driven bench for tdc_hit_pipeline: main instance with default parameters,
// a small CNT_W=4 instance for counter saturation.
module tb_tdc_hit_pipeline;

  localparam int W = 208;

  typedef struct {
    logic         rst;
    logic         en;
    logic [W-1:0] pin;
    logic [W-1:0] pout;
    logic         valid;
    logic         busy;
    logic [15:0]  cnt;
    logic [W-1:0] word;
  } vec_t;

  logic         clk;
  logic         rst, en;
  logic [W-1:0] pipe_in, pipe_out, hit_word;
  logic         hit_valid, busy;
  logic [15:0]  hit_count;

  logic         rst2, en2;
  logic [7:0]   pin2, pout2, word2;
  logic         valid2, busy2;
  logic [3:0]   cnt2;

  int nvec;
  int nmiss;
  vec_t vq[$];

  tdc_hit_pipeline dut (
    .clk(clk), .rst(rst), .en(en), .pipe_in(pipe_in), .pipe_out(pipe_out),
    .hit_word(hit_word), .hit_valid(hit_valid), .busy(busy), .hit_count(hit_count)
  );

  tdc_hit_pipeline #(.NFF(8), .NSTAGES(2), .HOLD_CYCLES(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst2), .en(en2), .pipe_in(pin2), .pipe_out(pout2),
    .hit_word(word2), .hit_valid(valid2), .busy(busy2), .hit_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [W-1:0] pi, input logic [W-1:0] po,
                     input logic v, input logic b, input logic [15:0] c, input logic [W-1:0] w);
    vec_t t;
    t.rst = r; t.en = e; t.pin = pi; t.pout = po;
    t.valid = v; t.busy = b; t.cnt = c; t.word = w;
    vq.push_back(t);
  endtask

  initial begin
    logic [W-1:0] all1;
    logic [W-1:0] ff;
    logic [W-1:0] f0;
    logic [W-1:0] z;
    logic [W-1:0] exp_w;
    int seen;
    int pulses;
    int waited;
    all1 = '1;
    ff   = 208'hFF;
    f0   = 208'h0F;
    z    = '0;
    nvec = 0;
    nmiss = 0;

    rst = 1'b1; en = 1'b1; pipe_in = all1;
    rst2 = 1'b1; en2 = 1'b1; pin2 = 8'h00;

    // rst en pin   pout valid busy cnt word
    add(1'b1, 1'b1, all1, z,  1'b0, 1'b0, 16'd0, z);
    add(1'b1, 1'b1, all1, z,  1'b0, 1'b0, 16'd0, z);
    add(1'b1, 1'b1, all1, z,  1'b0, 1'b0, 16'd0, z);
    add(1'b0, 1'b1, z,    z,  1'b0, 1'b0, 16'd0, z);
    add(1'b0, 1'b1, z,    z,  1'b0, 1'b0, 16'd0, z);
    add(1'b0, 1'b1, ff,   z,  1'b0, 1'b0, 16'd0, z);
    add(1'b0, 1'b1, ff,   ff, 1'b0, 1'b0, 16'd0, z);
    add(1'b0, 1'b1, z,    ff, 1'b1, 1'b1, 16'd1, ff);
    add(1'b0, 1'b1, ff,   z,  1'b0, 1'b1, 16'd1, ff);
    add(1'b0, 1'b1, ff,   ff, 1'b0, 1'b1, 16'd1, ff);
    add(1'b0, 1'b1, ff,   ff, 1'b0, 1'b1, 16'd1, ff);
    add(1'b0, 1'b1, ff,   ff, 1'b0, 1'b1, 16'd1, ff);
    add(1'b0, 1'b1, ff,   ff, 1'b0, 1'b1, 16'd1, ff);
    add(1'b0, 1'b1, z,    ff, 1'b0, 1'b1, 16'd1, ff);
    add(1'b0, 1'b1, f0,   z,  1'b0, 1'b1, 16'd1, ff);
    add(1'b0, 1'b1, f0,   f0, 1'b0, 1'b0, 16'd1, ff);
    add(1'b0, 1'b1, f0,   f0, 1'b1, 1'b1, 16'd2, f0);
    add(1'b0, 1'b1, f0,   f0, 1'b0, 1'b1, 16'd2, f0);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, z, f0, 1'b0, 1'b1, 16'd2, f0);
    add(1'b0, 1'b1, z,    f0, 1'b0, 1'b1, 16'd2, f0);
    add(1'b0, 1'b1, z,    z,  1'b0, 1'b1, 16'd2, f0);
    add(1'b0, 1'b1, z,    z,  1'b0, 1'b1, 16'd2, f0);
    add(1'b0, 1'b1, z,    z,  1'b0, 1'b1, 16'd2, f0);
    add(1'b0, 1'b1, z,    z,  1'b0, 1'b0, 16'd2, f0);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; en = vq[i].en; pipe_in = vq[i].pin;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.pipe_out", i), pipe_out, vq[i].pout);
      chk($sformatf("v%0d.hit_valid", i), {207'd0, hit_valid}, {207'd0, vq[i].valid});
      chk($sformatf("v%0d.busy", i), {207'd0, busy}, {207'd0, vq[i].busy});
      chk($sformatf("v%0d.hit_count", i), {192'd0, hit_count}, {192'd0, vq[i].cnt});
      chk($sformatf("v%0d.hit_word", i), hit_word, vq[i].word);
    end

    // Bubble-filter capture plus en stall inside CAPTURE.
`ifdef TDC_PIPE_BUBBLE_FILTER_EN
    exp_w = 208'h0F;
`else
    exp_w = 208'h17;
`endif
    @(negedge clk); rst = 1'b1; en = 1'b1; pipe_in = z;
    @(negedge clk); rst = 1'b0; pipe_in = 208'h17;
    @(negedge clk); pipe_in = z;
    @(posedge clk);
    @(posedge clk); #1;
    chk("filt.valid", {207'd0, hit_valid}, {207'd0, 1'b1});
    chk("filt.word", hit_word, exp_w);
    chk("filt.count", {192'd0, hit_count}, 208'd1);
    @(negedge clk); en = 1'b0; #1;
    chk("stall.valid_low", {207'd0, hit_valid}, 208'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("stall.valid_held_low", {207'd0, hit_valid}, 208'd0);
    chk("stall.busy", {207'd0, busy}, 208'd1);
    @(negedge clk); en = 1'b1; #1;
    chk("stall.valid_resume", {207'd0, hit_valid}, 208'd1);
    @(posedge clk); #1;
    chk("stall.valid_once", {207'd0, hit_valid}, 208'd0);
    chk("stall.count", {192'd0, hit_count}, 208'd1);

    waited = 0;
    while (busy && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("rearm.idle_timeout", {207'd0, busy}, 208'd0);

    // Reset at the edge that would enter CAPTURE drops the pending hit.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; pipe_in = 208'h1;
    @(negedge clk); pipe_in = z;
    @(negedge clk); rst = 1'b1; #1;
    chk("rstcap.pout_rise", pipe_out, 208'h1);
    @(posedge clk); #1;
    chk("rstcap.count", {192'd0, hit_count}, 208'd0);
    chk("rstcap.busy", {207'd0, busy}, 208'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (hit_valid) seen++;
    end
    chk("rstcap.no_valid", seen, 208'd0);
    chk("rstcap.count_after", {192'd0, hit_count}, 208'd0);

    // Saturation on the CNT_W=4 instance: 20 spaced hits.
    @(negedge clk); rst2 = 1'b0;
    pulses = 0;
    for (int h = 0; h < 20; h++) begin
      for (int c = 0; c < 10; c++) begin
        @(negedge clk); pin2 = (c == 0) ? 8'h01 : 8'h00;
        @(posedge clk); #1;
        if (valid2) pulses++;
      end
      chk($sformatf("sat.count_h%0d", h), {204'd0, cnt2}, (h + 1 > 15) ? 208'd15 : 208'(h + 1));
    end
    chk("sat.pulses", pulses, 208'd20);
    chk("sat.word", {200'd0, word2}, 208'h01);
    chk("sat.busy", {207'd0, busy2}, 208'd0);
    chk("sat.pout", {200'd0, pout2}, 208'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
